load_unit: RTL and testbench

Out-of-order OTTER load execution unit. Accepts one load from its reservation station, waits for base and offset operands, computes the effective address, and issues a single read on memory port 2. It aligns and sign/zero-extends the returned word, then broadcasts the result with its destination tag on the common data bus (CDB). It is the read-side counterpart of the store unit on the same memory port.

---
 rtl/otter_types_pkg.sv | 25 ++
 rtl/load_unit_if.sv | 44 ++++
 rtl/load_align.sv | 48 ++++
 rtl/load_unit.sv | 133 +++++++++++++
 tb/tb_load_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_types_pkg.sv
// Shared OTTER out-of-order types: RS tags, memory access sizes, load FSM states.
package otter_types_pkg;

  localparam int XLEN     = 32;
  localparam int RS_TAG_W = 4;

  typedef logic [RS_TAG_W-1:0] RS_tag_type;

  // funct3[1:0] encoding of the access size; 2'b11 is illegal.
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OPS,
    REQ,
    WAIT_MEM,
    BCAST,
    DRAIN
  } ld_state_t;

endpackage

// File: rtl/load_unit_if.sv
// Reservation-station, memory-port-2 and CDB signals of the load unit.
interface load_unit_if;
  import otter_types_pkg::*;

  // reservation station side
  logic                issue;
  logic [XLEN-1:0]     V1;
  logic [XLEN-1:0]     V2;
  logic                V1_valid;
  logic                V2_valid;
  RS_tag_type          rd_tag;
  logic [2:0]          mem_type;
  logic                flush;
  logic                busy;
  // memory port 2
  logic [XLEN-1:0]     mem_rdata;
  logic                mem_rvalid;
  logic [XLEN-1:0]     MEM_ADDR2;
  logic                MEM_READ2;
  logic [1:0]          MEM_SIZE;
  // common data bus
  logic                cdb_grant;
  logic                cdb_valid;
  RS_tag_type          cdb_tag;
  logic [XLEN-1:0]     cdb_data;
  logic                cdb_fault;

  // load unit side
  modport slave (
    input  issue, V1, V2, V1_valid, V2_valid, rd_tag, mem_type, flush,
           mem_rdata, mem_rvalid, cdb_grant,
    output busy, MEM_ADDR2, MEM_READ2, MEM_SIZE,
           cdb_valid, cdb_tag, cdb_data, cdb_fault
  );

  // RS / memory / arbiter side
  modport master (
    output issue, V1, V2, V1_valid, V2_valid, rd_tag, mem_type, flush,
           mem_rdata, mem_rvalid, cdb_grant,
    input  busy, MEM_ADDR2, MEM_READ2, MEM_SIZE,
           cdb_valid, cdb_tag, cdb_data, cdb_fault
  );

endinterface

// File: rtl/load_align.sv
// Combinational load alignment: lane select, sign/zero extension, misalignment flag.
module load_align
  import otter_types_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      mem_type_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic        unsigned_ld;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = word_i[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = word_i[16*gi +: 16];
    end
  endgenerate

  assign unsigned_ld = mem_type_i[2];

  // Select the addressed lane, extend it, and flag illegal size/alignment.
  always_comb begin
    data_o     = '0;
    misalign_o = 1'b0;
    case (mem_size_t'(mem_type_i[1:0]))
      BYTE: begin
        data_o = {{(XLEN-8){~unsigned_ld & byte_lane[addr_i][7]}}, byte_lane[addr_i]};
      end
      HALF: begin
        data_o     = {{(XLEN-16){~unsigned_ld & half_lane[addr_i[1]][15]}}, half_lane[addr_i[1]]};
        misalign_o = addr_i[0];
      end
      WORD: begin
        data_o     = word_i;
        misalign_o = |addr_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// OTTER load execution unit: operand wait, address check, single read on
// memory port 2, result alignment and CDB broadcast. Outputs are all registered.
module load_unit
  import otter_types_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  load_unit_if.slave lu
);

  ld_state_t       state_q, state_d;
  RS_tag_type      tag_q, tag_d;
  logic [2:0]      type_q, type_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;
  logic            busy_q, read_q, valid_q;

  logic [XLEN-1:0] eff_addr;
  logic [2:0]      cur_type;
  logic [1:0]      al_addr;
  logic [XLEN-1:0] al_data;
  logic            al_misalign;
  logic            ops_ready;

  assign eff_addr  = lu.V1 + lu.V2;
  assign ops_ready = lu.V1_valid & lu.V2_valid;
  // In IDLE the type comes straight from the issuing RS entry; later it is latched.
  assign cur_type  = (state_q == IDLE) ? lu.mem_type : type_q;
  // One aligner serves both the address check and the response extraction.
  assign al_addr   = (state_q == WAIT_MEM) ? addr_q[1:0] : eff_addr[1:0];

  load_align u_align (
    .word_i     (lu.mem_rdata),
    .addr_i     (al_addr),
    .mem_type_i (cur_type),
    .data_o     (al_data),
    .misalign_o (al_misalign)
  );

  // Next-state and datapath-register selection.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (lu.issue) begin
          tag_d   = lu.rd_tag;
          type_d  = lu.mem_type;
          data_d  = '0;
          fault_d = 1'b0;
          if (ops_ready) begin
            addr_d  = eff_addr;
            fault_d = al_misalign;
            state_d = al_misalign ? BCAST : REQ;
          end else begin
            state_d = WAIT_OPS;
          end
        end
      end
      WAIT_OPS: begin
        if (lu.flush) begin
          state_d = IDLE;
        end else if (ops_ready) begin
          addr_d  = eff_addr;
          fault_d = al_misalign;
          state_d = al_misalign ? BCAST : REQ;
        end
      end
      REQ: state_d = lu.flush ? IDLE : WAIT_MEM;
      WAIT_MEM: begin
        if (lu.mem_rvalid) begin
          // A response arriving with the flush is consumed, so no drain is needed.
          if (lu.flush) begin
            state_d = IDLE;
          end else begin
            data_d  = al_data;
            fault_d = 1'b0;
            state_d = BCAST;
          end
        end else if (lu.flush) begin
          state_d = DRAIN;
        end
      end
      BCAST: begin
        if (lu.cdb_grant || lu.flush) state_d = IDLE;
      end
      DRAIN: begin
        if (lu.mem_rvalid || lu.flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; status outputs decode the upcoming state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tag_q   <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      busy_q  <= (state_d != IDLE);
      read_q  <= (state_d == REQ);
      valid_q <= (state_d == BCAST);
    end
  end

  assign lu.busy      = busy_q;
  assign lu.MEM_ADDR2 = addr_q;
  assign lu.MEM_READ2 = read_q;
  assign lu.MEM_SIZE  = type_q[1:0];
  assign lu.cdb_valid = valid_q;
  assign lu.cdb_tag   = tag_q;
  assign lu.cdb_data  = data_q;
  assign lu.cdb_fault = fault_q;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: driver pushes expected requests/broadcasts,
// a monitor pops and compares whenever the DUT presents them.
module tb_load_unit;
  import otter_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  load_unit_if lu ();

  load_unit dut (
    .CLK (CLK),
    .RST (RST),
    .lu  (lu)
  );

  typedef struct {
    RS_tag_type  tag;
    logic [31:0] data;
    logic        fault;
  } bc_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
  } rq_t;

  bc_t bc_q[$];
  rq_t rq_q[$];
  int  checks = 0;
  int  passes = 0;
  bit  mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: RISC-V load semantics from address, funct3 and memory word.
  function automatic void ref_load(input logic [31:0] addr, input logic [2:0] t,
                                   input logic [31:0] word,
                                   output logic fault, output logic [31:0] data);
    int unsigned a;
    int unsigned sz;
    a  = addr;
    sz = t % 4;
    fault = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    data  = 0;
    if (!fault) begin
      if (sz == 0) begin
        data = (word >> (8 * (a % 4))) & 32'hFF;
        if (!t[2] && data >= 128) data = data | 32'hFFFF_FF00;
      end else if (sz == 1) begin
        data = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (!t[2] && data >= 32768) data = data | 32'hFFFF_0000;
      end else begin
        data = word;
      end
    end
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},  lu.busy, 0);
    check({pfx, "_read"},  lu.MEM_READ2, 0);
    check({pfx, "_addr"},  lu.MEM_ADDR2, 0);
    check({pfx, "_size"},  lu.MEM_SIZE, 0);
    check({pfx, "_valid"}, lu.cdb_valid, 0);
    check({pfx, "_tag"},   lu.cdb_tag, 0);
    check({pfx, "_data"},  lu.cdb_data, 0);
    check({pfx, "_fault"}, lu.cdb_fault, 0);
  endtask

  // Monitor: every request pulse and every broadcast cycle is checked against the queues.
  initial begin : monitor
    rq_t r;
    bc_t b;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (lu.MEM_READ2 === 1'b1) begin
          check("req_expected", rq_q.size() > 0, 1);
          if (rq_q.size() > 0) begin
            r = rq_q.pop_front();
            check("req_addr", lu.MEM_ADDR2, r.addr);
            check("req_size", lu.MEM_SIZE, r.size);
            $display("req  addr=%h size=%0d", lu.MEM_ADDR2, lu.MEM_SIZE);
          end
        end
        if (lu.cdb_valid === 1'b1) begin
          check("bc_expected", bc_q.size() > 0, 1);
          if (bc_q.size() > 0) begin
            b = bc_q[0];
            check("bc_tag", lu.cdb_tag, b.tag);
            check("bc_data", lu.cdb_data, b.data);
            check("bc_fault", lu.cdb_fault, b.fault);
            if (lu.cdb_grant || lu.flush) begin
              b = bc_q.pop_front();
              $display("bcast tag=%0d data=%h fault=%0d", lu.cdb_tag, lu.cdb_data, lu.cdb_fault);
            end
          end
        end
      end
    end
  end

  // Issue one load (called at posedge+1) and run it to its granted broadcast.
  // Returns at posedge+1 of the cycle after the grant.
  task automatic run_load(input logic [2:0] t, input logic [31:0] v1, input logic [31:0] v2,
                          input RS_tag_type tag, input logic [31:0] word,
                          input int ops_delay, input int mem_delay, input int grant_delay);
    logic [31:0] addr, exp_data;
    logic        exp_fault;
    int          req_cyc, bc_cyc, n, exp_bc;
    bit          done;
    addr = v1 + v2;
    ref_load(addr, t, word, exp_fault, exp_data);
    bc_q.push_back('{tag, exp_data, exp_fault});
    if (!exp_fault) rq_q.push_back('{addr, t[1:0]});
    exp_bc = exp_fault ? ops_delay + 1 : ops_delay + 2 + mem_delay;
    lu.issue = 1; lu.V1 = v1; lu.V2 = v2; lu.rd_tag = tag; lu.mem_type = t;
    lu.V1_valid = 1; lu.V2_valid = (ops_delay == 0);
    @(negedge CLK);
    check("idle_at_issue", {lu.busy, lu.cdb_valid}, 0);
    @(posedge CLK); #1;
    lu.issue = 0;
    req_cyc = -1; bc_cyc = -1; done = 0; n = 1;
    while (!done && n < 64) begin
      lu.V2_valid   = (n >= ops_delay);
      lu.mem_rvalid = (req_cyc >= 0 && n == req_cyc + mem_delay) ||
                      ((req_cyc < 0 || bc_cyc >= 0) && ($urandom_range(0, 1) == 1));
      lu.mem_rdata  = (req_cyc >= 0 && n == req_cyc + mem_delay) ? word : $urandom;
      lu.cdb_grant  = (bc_cyc >= 0 && n >= bc_cyc + grant_delay);
      @(negedge CLK);
      if (n == 1) check("busy_after_issue", lu.busy, 1);
      if (lu.MEM_READ2 && req_cyc < 0) begin
        req_cyc = n;
        check("req_latency", n, ops_delay + 1);
      end
      if (lu.cdb_valid && bc_cyc < 0) begin
        bc_cyc = n;
        check("bc_latency", n, exp_bc);
      end
      if (lu.cdb_valid && lu.cdb_grant) done = 1;
      @(posedge CLK); #1;
      n++;
    end
    check("load_completed", done, 1);
    $display("load type=%0d addr=%h tag=%0d exp_data=%h exp_fault=%0d", t, addr, tag, exp_data, exp_fault);
    lu.cdb_grant = 0; lu.mem_rvalid = 0; lu.V1_valid = 0; lu.V2_valid = 0;
  endtask

  // Flush while waiting for memory; the response either coincides or arrives 2 cycles later.
  task automatic flush_wait_mem(input bit same_cycle);
    rq_q.push_back('{32'h0000_2008, 2'b10});
    lu.issue = 1; lu.V1 = 32'h2000; lu.V2 = 8; lu.rd_tag = 4'h9; lu.mem_type = 3'b010;
    lu.V1_valid = 1; lu.V2_valid = 1;
    @(posedge CLK); #1;
    lu.issue = 0; lu.V1_valid = 0; lu.V2_valid = 0;
    @(negedge CLK);
    check("flush_req_pulse", lu.MEM_READ2, 1);
    @(posedge CLK); #1;
    lu.flush = 1; lu.mem_rvalid = same_cycle; lu.mem_rdata = 32'h1234_5678;
    @(posedge CLK); #1;
    lu.flush = 0; lu.mem_rvalid = 0;
    if (!same_cycle) begin
      @(negedge CLK);
      check("drain_busy_0", lu.busy, 1);
      @(posedge CLK); #1;
      lu.mem_rvalid = 1;
      @(negedge CLK);
      check("drain_busy_1", lu.busy, 1);
      @(posedge CLK); #1;
      lu.mem_rvalid = 0;
    end
    $display("flush in WAIT_MEM same_cycle_rsp=%0d", same_cycle);
  endtask

  // Flush while operands are outstanding: no request, unit frees next cycle.
  task automatic flush_wait_ops();
    lu.issue = 1; lu.V1 = 32'h3000; lu.V2 = 0; lu.rd_tag = 4'h3; lu.mem_type = 3'b010;
    lu.V1_valid = 1; lu.V2_valid = 0;
    @(posedge CLK); #1;
    lu.issue = 0; lu.flush = 1;
    @(negedge CLK);
    check("wops_busy", lu.busy, 1);
    @(posedge CLK); #1;
    lu.flush = 0; lu.V2_valid = 1;
    @(negedge CLK);
    check("wops_flushed_idle", lu.busy, 0);
    @(posedge CLK); #1;
    lu.V1_valid = 0; lu.V2_valid = 0;
    $display("flush in WAIT_OPS");
  endtask

  // Reset in WAIT_MEM: everything clears and the late response is ignored.
  task automatic reset_wait_mem();
    rq_q.push_back('{32'h0000_4000, 2'b10});
    lu.issue = 1; lu.V1 = 32'h4000; lu.V2 = 0; lu.rd_tag = 4'hC; lu.mem_type = 3'b010;
    lu.V1_valid = 1; lu.V2_valid = 1;
    @(posedge CLK); #1;
    lu.issue = 0; lu.V1_valid = 0; lu.V2_valid = 0;
    @(posedge CLK); #1;
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    @(negedge CLK);
    check_all_zero("rst_wmem");
    @(posedge CLK); #1;
    lu.mem_rvalid = 1; lu.mem_rdata = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    lu.mem_rvalid = 0;
    @(negedge CLK);
    check("rst_late_rsp_idle", {lu.busy, lu.cdb_valid}, 0);
    @(posedge CLK); #1;
    $display("reset in WAIT_MEM");
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    logic [2:0]  t;
    logic [31:0] v1, v2;
    int          sel;
    lu.issue = 0; lu.V1 = 0; lu.V2 = 0; lu.V1_valid = 0; lu.V2_valid = 0;
    lu.rd_tag = 0; lu.mem_type = 0; lu.flush = 0; lu.mem_rdata = 0;
    lu.mem_rvalid = 0; lu.cdb_grant = 0;
    RST = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    check_all_zero("reset");
    mon_en = 1;
    @(posedge CLK); #1;

    // directed loads
    run_load(3'b010, 32'h1000, 32'd4, 4'h5, 32'hDEAD_BEEF, 0, 1, 1);
    run_load(3'b000, 32'h1000, 32'd3, 4'h6, 32'h80FF_FF7F, 0, 1, 1);
    run_load(3'b100, 32'h1000, 32'd3, 4'h7, 32'h80FF_FF7F, 0, 2, 1);
    run_load(3'b101, 32'h1000, 32'd2, 4'h8, 32'h80FF_FF7F, 0, 1, 2);
    run_load(3'b001, 32'h1000, 32'd1, 4'hA, 32'h1111_2222, 0, 1, 1);
    run_load(3'b011, 32'h1000, 32'd0, 4'hB, 32'h1111_2222, 0, 1, 1);
    run_load(3'b001, 32'hFFFF_FFFE, 32'd4, 4'h1, 32'h8001_7FFF, 0, 1, 1);
    run_load(3'b010, 32'h1FF0, 32'h0000_0010, 4'h2, 32'h0BAD_CAFE, 4, 3, 5);
    flush_wait_mem(0);
    run_load(3'b000, 32'h1234, 32'd1, 4'hD, 32'h00A5_0000, 0, 1, 1);
    flush_wait_mem(1);
    run_load(3'b100, 32'h1234, 32'd2, 4'hE, 32'h00A5_0000, 0, 1, 1);
    flush_wait_ops();
    reset_wait_mem();
    run_load(3'b010, 32'h1000, 32'd4, 4'hF, 32'h0F0F_0F0F, 1, 1, 1);

    // randomized loads
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    t = 3'b000;
        2:       t = 3'b100;
        3, 4:    t = 3'b001;
        5:       t = 3'b101;
        6, 7:    t = 3'b010;
        8:       t = 3'b011;
        default: t = 3'b110;
      endcase
      v1 = ($urandom_range(0, 7) == 0) ? $urandom : 32'h1000 + $urandom_range(0, 1023);
      v2 = $urandom_range(0, 15) - 8;
      run_load(t, v1, v2, RS_tag_type'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(1, 3));
    end

    repeat (4) @(posedge CLK);
    check("bc_queue_empty", bc_q.size(), 0);
    check("rq_queue_empty", rq_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
